// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI mode encodings (MODE_HOLD, MODE_LEFT, MODE_RIGHT, MODE_PLOAD)
package spi_pkg;
  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_PLOAD = 2'b11;
endpackage

// File: rtl/shift_register_8.sv
// shift_register_8: strobed load/hold/shift register; ports clk, rst_n, serialClkposedge, mode, parallelIn, serialIn -> parallelOut, serialOut (MSB)
module shift_register_8
  import spi_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serialClkposedge,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] parallelIn,
  input  logic             serialIn,
  output logic [WIDTH-1:0] parallelOut,
  output logic             serialOut
);
  logic [WIDTH-1:0] q;
  always_ff @(posedge clk)
    if (!rst_n) q <= '0;
    else if (serialClkposedge)
      q <= mode == MODE_LEFT  ? {q[WIDTH-2:0], serialIn} :
           mode == MODE_RIGHT ? {serialIn, q[WIDTH-1:1]} :
           mode == MODE_PLOAD ? parallelIn : q;
  assign parallelOut = q;
  assign serialOut = q[WIDTH-1];
endmodule

// File: tb/tb_shift_register_8.sv
// tb_shift_register_8: arithmetic reference model plus directed literal checks for shift_register_8
module tb_shift_register_8;
  import spi_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  logic serialClkposedge = 0;
  logic serialIn = 0;
  logic [1:0] mode = MODE_HOLD;
  logic [7:0] parallelIn = 8'h00;
  logic [7:0] parallelOut;
  logic serialOut;
  int n_checks = 0;
  int n_fail = 0;
  int unsigned model = 0;
  int unsigned prev_model = 0;
  bit model_valid = 0;
  bit hold_expected = 0;
  logic [7:0] left_exp [5] = '{8'h08, 8'h11, 8'h23, 8'h47, 8'h8F};
  logic left_sin [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic right_sin [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  shift_register_8 #(.WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .serialClkposedge(serialClkposedge),
    .mode(mode),
    .parallelIn(parallelIn),
    .serialIn(serialIn),
    .parallelOut(parallelOut),
    .serialOut(serialOut)
  );

  always #5 clk = ~clk;

  function automatic int unsigned next_model(int unsigned m, logic r, logic s, logic [1:0] md,
                                             logic [7:0] p, logic si);
    if (!r) return 0;
    if (!s) return m;
    case (md)
      MODE_LEFT:  return (m * 2 + int'(si)) % 256;
      MODE_RIGHT: return m / 2 + int'(si) * 128;
      MODE_PLOAD: return int'(p);
      default:    return m;
    endcase
  endfunction

  always @(posedge clk) begin
    prev_model <= model;
    hold_expected <= rst_n && !serialClkposedge && model_valid;
    model <= next_model(model, rst_n, serialClkposedge, mode, parallelIn, serialIn);
    if (!rst_n) model_valid <= 1;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (model_valid) begin
      chk("model_parallelOut", parallelOut, model[7:0]);
      chk("serialOut_is_msb", {7'b0, serialOut}, {7'b0, parallelOut[7]});
      if (hold_expected) chk("strobe_low_stable", parallelOut, prev_model[7:0]);
    end

  task automatic cyc(input logic r, input logic s, input logic [1:0] m, input logic [7:0] p,
                     input logic si);
    @(negedge clk);
    rst_n = r;
    serialClkposedge = s;
    mode = m;
    parallelIn = p;
    serialIn = si;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(0, 0, MODE_HOLD, 8'h00, 0);
    chk("reset_value", parallelOut, 8'h00);
    chk("reset_serialOut", {7'b0, serialOut}, 8'h00);
    cyc(0, 1, MODE_PLOAD, 8'hFF, 1);
    chk("reset_beats_pload", parallelOut, 8'h00);
    cyc(1, 1, MODE_PLOAD, 8'hFF, 0);
    chk("pload_ff", parallelOut, 8'hFF);
    cyc(1, 1, MODE_PLOAD, 8'h00, 0);
    chk("pload_00", parallelOut, 8'h00);
    cyc(1, 1, MODE_PLOAD, 8'hF7, 0);
    chk("pload_f7", parallelOut, 8'hF7);
    cyc(1, 1, MODE_PLOAD, 8'h7F, 0);
    cyc(1, 1, MODE_HOLD, 8'h78, 1);
    chk("hold_1", parallelOut, 8'h7F);
    cyc(1, 1, MODE_HOLD, 8'h2C, 1);
    chk("hold_2", parallelOut, 8'h7F);
    cyc(1, 1, MODE_HOLD, 8'h78, 1);
    chk("hold_3", parallelOut, 8'h7F);
    cyc(1, 1, MODE_PLOAD, 8'h04, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, MODE_LEFT, 8'hC3, left_sin[i]);
      chk("left_step", parallelOut, left_exp[i]);
      chk("left_serialOut", {7'b0, serialOut}, {7'b0, i == 4});
    end
    cyc(1, 1, MODE_PLOAD, 8'h00, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, MODE_RIGHT, 8'h5A, right_sin[i]);
      chk("right_serialOut", {7'b0, serialOut}, {7'b0, right_sin[i]});
    end
    chk("right_final", parallelOut, 8'h95);
    cyc(1, 1, MODE_PLOAD, 8'hA5, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, i % 2 ? MODE_RIGHT : MODE_LEFT, 8'(i * 37), 1'(i));
      chk("strobe_low_a5", parallelOut, 8'hA5);
    end
    cyc(1, 1, MODE_PLOAD, 8'hFF, 0);
    cyc(1, 1, MODE_LEFT, 8'h00, 1);
    chk("left_ff_1", parallelOut, 8'hFF);
    cyc(1, 1, MODE_LEFT, 8'h00, 1);
    chk("left_ff_2", parallelOut, 8'hFF);
    cyc(0, 1, MODE_LEFT, 8'h00, 1);
    chk("reset_mid_shift", parallelOut, 8'h00);
    cyc(1, 1, MODE_LEFT, 8'h00, 1);
    chk("after_reset_left", parallelOut, 8'h01);
    for (int i = 0; i < 60; i++)
      cyc(($urandom_range(0, 15) != 0), 1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom));
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
